// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline run-control logic: FSM state encoding,
// the HALT opcode and the default register-address width.
package pipe_ctrl_pkg;

    localparam int REG_ADDR_W = 5;

    localparam logic [5:0] HALT_OPCODE = 6'b111111;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RUN       = 3'd1,
        ST_STEP_WAIT = 3'd2,
        ST_STEP_EXEC = 3'd3,
        ST_DRAIN     = 3'd4,
        ST_HALTED    = 3'd5
    } seq_state_t;

    function automatic logic is_halt_opcode(input logic [5:0] opcode);
        return opcode == HALT_OPCODE;
    endfunction

endpackage

// File: rtl/hazard_unit.sv
// Combinational load-use hazard detection between the load in EX and the
// source registers of the instruction in ID.
module hazard_unit #(
    parameter int REG_ADDR_W = 5
) (
    input  logic                  id_ex_mem_read,
    input  logic [REG_ADDR_W-1:0] id_ex_rt,
    input  logic [REG_ADDR_W-1:0] if_id_rs,
    input  logic [REG_ADDR_W-1:0] if_id_rt,
    output logic                  stall
);

    // Register 0 is hard-wired, so a load into it never creates a dependency.
    always_comb begin
        stall = id_ex_mem_read
              && (id_ex_rt != '0)
              && ((id_ex_rt == if_id_rs) || (id_ex_rt == if_id_rt));
    end

endmodule

// File: rtl/pipeline_sequencer.sv
// Run-control and hazard sequencer for the 5-stage pipeline: free-run and
// single-step execution, load-use stalls, branch flushes and HALT drain.
module pipeline_sequencer #(
    parameter int CNT_W        = 32,
    parameter int DRAIN_CYCLES = 3,
    parameter int REG_ADDR_W   = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  step_mode,
    input  logic                  step,
    input  logic                  halt_detected,
    input  logic                  branch_taken,
    input  logic                  id_ex_mem_read,
    input  logic [REG_ADDR_W-1:0] id_ex_rt,
    input  logic [REG_ADDR_W-1:0] if_id_rs,
    input  logic [REG_ADDR_W-1:0] if_id_rt,
    output logic                  pc_enable,
    output logic                  if_id_enable,
    output logic                  pipe_enable,
    output logic                  if_id_flush,
    output logic                  id_ex_flush,
    output logic                  running,
    output logic                  halted,
    output logic [CNT_W-1:0]      cycle_count
);
    import pipe_ctrl_pkg::*;

    localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    seq_state_t         state;
    seq_state_t         next_state;
    logic [DRAIN_W-1:0] drain_cnt;
    logic               stall;
    logic               active;
    logic               halt_go;
    logic               start_ok;

    hazard_unit #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_hazard (
        .id_ex_mem_read (id_ex_mem_read),
        .id_ex_rt       (id_ex_rt),
        .if_id_rs       (if_id_rs),
        .if_id_rt       (if_id_rt),
        .stall          (stall)
    );

    // A stall takes priority over HALT so the halted instruction re-presents itself.
    assign active   = (state == ST_RUN) || (state == ST_STEP_EXEC);
    assign halt_go  = active && halt_detected && !stall;
    assign start_ok = start && ((state == ST_IDLE) || (state == ST_HALTED));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            running <= 1'b0;
            halted  <= 1'b0;
        end else begin
            state   <= next_state;
            running <= (next_state == ST_RUN) || (next_state == ST_STEP_WAIT)
                    || (next_state == ST_STEP_EXEC) || (next_state == ST_DRAIN);
            halted  <= (next_state == ST_HALTED);
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE, ST_HALTED: begin
                if (start) next_state = step_mode ? ST_STEP_WAIT : ST_RUN;
            end
            ST_RUN: begin
                if (halt_go) next_state = ST_DRAIN;
            end
            ST_STEP_WAIT: begin
                if (step) next_state = ST_STEP_EXEC;
            end
            ST_STEP_EXEC: begin
                next_state = halt_go ? ST_DRAIN : ST_STEP_WAIT;
            end
            ST_DRAIN: begin
                if (drain_cnt == '0) next_state = ST_HALTED;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        pc_enable    = 1'b0;
        if_id_enable = 1'b0;
        pipe_enable  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        case (state)
            ST_RUN, ST_STEP_EXEC: begin
                pipe_enable = 1'b1;
                if (stall) begin
                    id_ex_flush = 1'b1;
                end else if (halt_detected) begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end else begin
                    pc_enable    = 1'b1;
                    if_id_enable = 1'b1;
                    if_id_flush  = branch_taken;
                end
            end
            ST_DRAIN: begin
                pipe_enable = 1'b1;
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drain_cnt <= '0;
        end else if (halt_go) begin
            drain_cnt <= DRAIN_W'(DRAIN_CYCLES - 1);
        end else if ((state == ST_DRAIN) && (drain_cnt != '0)) begin
            drain_cnt <= drain_cnt - 1'b1;
        end
    end

    // Saturates rather than wraps so the debug unit never sees a small count after a long run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_count <= '0;
        end else if (start_ok) begin
            cycle_count <= '0;
        end else if (pipe_enable && (cycle_count != '1)) begin
            cycle_count <= cycle_count + 1'b1;
        end
    end

endmodule
